// File: rtl/scratchpad_mem_responder_pkg.sv
// Memory-op command encodings and helpers shared by the scratchpad responder.
// Extended with a flush-class predicate and an AMO operation decode.
package scratchpad_mem_responder_pkg;

  localparam logic [4:0] M_XRD       = 5'h00;
  localparam logic [4:0] M_XWR       = 5'h01;
  localparam logic [4:0] M_PFR       = 5'h02;
  localparam logic [4:0] M_PFW       = 5'h03;
  localparam logic [4:0] M_XA_SWAP   = 5'h04;
  localparam logic [4:0] M_FLUSH_ALL = 5'h05;
  localparam logic [4:0] M_XLR       = 5'h06;
  localparam logic [4:0] M_XSC       = 5'h07;
  localparam logic [4:0] M_XA_ADD    = 5'h08;
  localparam logic [4:0] M_XA_XOR    = 5'h09;
  localparam logic [4:0] M_XA_OR     = 5'h0a;
  localparam logic [4:0] M_XA_AND    = 5'h0b;
  localparam logic [4:0] M_XA_MIN    = 5'h0c;
  localparam logic [4:0] M_XA_MAX    = 5'h0d;
  localparam logic [4:0] M_XA_MINU   = 5'h0e;
  localparam logic [4:0] M_XA_MAXU   = 5'h0f;
  localparam logic [4:0] M_FLUSH     = 5'h10;
  localparam logic [4:0] M_PWR       = 5'h11;
  localparam logic [4:0] M_PRODUCE   = 5'h12;
  localparam logic [4:0] M_CLEAN     = 5'h13;
  localparam logic [4:0] M_SFENCE    = 5'h14;
  localparam logic [4:0] M_HFENCEV   = 5'h15;
  localparam logic [4:0] M_HFENCEG   = 5'h16;
  localparam logic [4:0] M_WOK       = 5'h17;
  localparam logic [4:0] M_HLVX      = 5'h18;

  typedef enum logic [3:0] {
    AmoSwap, AmoAdd, AmoXor, AmoOr, AmoAnd, AmoMin, AmoMax, AmoMinu, AmoMaxu
  } amo_op_e;

  function automatic logic isAMO(input logic [4:0] cmd);
    return (cmd == M_XA_SWAP) || ((cmd >= M_XA_ADD) && (cmd <= M_XA_MAXU));
  endfunction

  function automatic logic isWrite(input logic [4:0] cmd);
    return (cmd == M_XWR) || (cmd == M_PWR) || (cmd == M_XSC) || isAMO(cmd);
  endfunction

  function automatic logic isPrefetch(input logic [4:0] cmd);
    return (cmd == M_PFR) || (cmd == M_PFW);
  endfunction

  function automatic logic isFlushClass(input logic [4:0] cmd);
    return (cmd == M_FLUSH_ALL) || (cmd == M_FLUSH) || (cmd == M_PRODUCE) ||
           (cmd == M_CLEAN) || (cmd == M_SFENCE) || (cmd == M_WOK);
  endfunction

  // Non-AMO commands decode as swap so a store-conditional can reuse the ALU path.
  function automatic amo_op_e amo_op_of(input logic [4:0] cmd);
    case (cmd)
      M_XA_ADD:  return AmoAdd;
      M_XA_XOR:  return AmoXor;
      M_XA_OR:   return AmoOr;
      M_XA_AND:  return AmoAnd;
      M_XA_MIN:  return AmoMin;
      M_XA_MAX:  return AmoMax;
      M_XA_MINU: return AmoMinu;
      M_XA_MAXU: return AmoMaxu;
      default:   return AmoSwap;
    endcase
  endfunction

endpackage

// File: rtl/scratchpad_mem_responder_amo_alu.sv
// Combinational AMO datapath: merges op(old, operand) into the dword and
// returns the byte write mask (one 32-bit half for size 2, whole dword otherwise).
module scratchpad_mem_responder_amo_alu
  import scratchpad_mem_responder_pkg::*;
(
  input  logic [4:0]  cmd,
  input  logic [1:0]  size,
  input  logic        addr2,
  input  logic [63:0] old,
  input  logic [63:0] operand,
  output logic [63:0] new_data,
  output logic [7:0]  wmask
);

  amo_op_e     op;
  logic [31:0] a32, b32, r32;
  logic [63:0] r64;

  always_comb begin
    op  = amo_op_of(cmd);
    a32 = addr2 ? old[63:32] : old[31:0];
    b32 = operand[31:0];
    r32 = b32;
    r64 = operand;
    unique case (op)
      AmoSwap: begin r32 = b32;       r64 = operand;       end
      AmoAdd:  begin r32 = a32 + b32; r64 = old + operand; end
      AmoXor:  begin r32 = a32 ^ b32; r64 = old ^ operand; end
      AmoOr:   begin r32 = a32 | b32; r64 = old | operand; end
      AmoAnd:  begin r32 = a32 & b32; r64 = old & operand; end
      AmoMin: begin
        r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
        r64 = ($signed(old) < $signed(operand)) ? old : operand;
      end
      AmoMax: begin
        r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
        r64 = ($signed(old) > $signed(operand)) ? old : operand;
      end
      AmoMinu: begin
        r32 = (a32 < b32) ? a32 : b32;
        r64 = (old < operand) ? old : operand;
      end
      AmoMaxu: begin
        r32 = (a32 > b32) ? a32 : b32;
        r64 = (old > operand) ? old : operand;
      end
      default: begin r32 = b32; r64 = operand; end
    endcase

    if (size == 2'd2) begin
      new_data = addr2 ? {r32, old[31:0]} : {old[63:32], r32};
      wmask    = addr2 ? 8'hf0 : 8'h0f;
    end else begin
      new_data = r64;
      wmask    = 8'hff;
    end
  end

endmodule

// File: rtl/scratchpad_mem_responder.sv
// Single-outstanding memory responder over a local 64-bit scratchpad:
// loads, (partial) stores, LR/SC and AMOs, with tagged registered responses.
module scratchpad_mem_responder
  import scratchpad_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH) + 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_data,
  input  logic [7:0]        req_mask,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_has_data,
  output logic              resp_error
);

  localparam int unsigned IDX_W = ADDR_W - 3;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q;
  logic [4:0]         cmd_q;
  logic [IDX_W-1:0]   idx_q;
  logic               addr2_q;
  logic [1:0]         size_q;
  logic [63:0]        data_q;
  logic [7:0]         mask_q;
  logic [TAG_W-1:0]   tag_q;
  logic [63:0]        rdata_q;
  logic               resv_valid_q;
  logic [IDX_W-1:0]   resv_idx_q;
  logic               resp_valid_q;
  logic [63:0]        resp_data_q;
  logic [TAG_W-1:0]   resp_tag_q;
  logic               resp_has_data_q;
  logic               resp_error_q;

  logic [63:0]        mem [DEPTH];

  logic               accept;
  logic               is_amo, is_store, is_sc, sc_ok;
  logic               exec_we, mem_we, supported, has_data;
  logic [63:0]        alu_new, exec_wdata, exec_rdata;
  logic [7:0]         alu_mask, exec_wmask;
  logic               unused_addr;

  assign unused_addr = ^req_addr[1:0];

  assign req_ready = (state_q == StIdle) && reset_n;
  assign accept    = req_valid && req_ready;

  scratchpad_mem_responder_amo_alu u_amo_alu (
    .cmd      (cmd_q),
    .size     (size_q),
    .addr2    (addr2_q),
    .old      (rdata_q),
    .operand  (data_q),
    .new_data (alu_new),
    .wmask    (alu_mask)
  );

  always_comb begin
    is_amo     = isAMO(cmd_q);
    is_store   = (cmd_q == M_XWR) || (cmd_q == M_PWR);
    is_sc      = (cmd_q == M_XSC);
    sc_ok      = is_sc && resv_valid_q && (resv_idx_q == idx_q);
    exec_we    = isWrite(cmd_q) && (!is_sc || sc_ok);
    exec_wmask = is_store ? mask_q : alu_mask;
    exec_wdata = is_store ? data_q : alu_new;
    supported  = (cmd_q == M_XRD) || is_store || (cmd_q == M_XLR) || is_sc || is_amo ||
                 isPrefetch(cmd_q) || isFlushClass(cmd_q);
    has_data   = (cmd_q == M_XRD) || (cmd_q == M_XLR) || is_sc || is_amo;
    exec_rdata = '0;
    if (is_sc) begin
      exec_rdata = {63'b0, !sc_ok};
    end else if (has_data) begin
      exec_rdata = rdata_q;
    end
  end

  // A reset sampled on the EXEC edge suppresses the write.
  assign mem_we = (state_q == StExec) && reset_n && exec_we;

  always_ff @(posedge clock) begin
    if (accept) begin
      rdata_q <= mem[req_addr[ADDR_W-1:3]];
    end
    for (int i = 0; i < 8; i++) begin
      if (mem_we && exec_wmask[i]) begin
        mem[idx_q][8*i +: 8] <= exec_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      cmd_q           <= '0;
      idx_q           <= '0;
      addr2_q         <= 1'b0;
      size_q          <= '0;
      data_q          <= '0;
      mask_q          <= '0;
      tag_q           <= '0;
      resv_valid_q    <= 1'b0;
      resv_idx_q      <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_tag_q      <= '0;
      resp_has_data_q <= 1'b0;
      resp_error_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cmd_q   <= req_cmd;
            idx_q   <= req_addr[ADDR_W-1:3];
            addr2_q <= req_addr[2];
            size_q  <= req_size;
            data_q  <= req_data;
            mask_q  <= req_mask;
            tag_q   <= req_tag;
            state_q <= StExec;
          end
        end
        StExec: begin
          resp_valid_q    <= 1'b1;
          resp_data_q     <= supported ? exec_rdata : 64'b0;
          resp_tag_q      <= tag_q;
          resp_has_data_q <= supported && has_data;
          resp_error_q    <= !supported;
          if (cmd_q == M_XLR) begin
            resv_valid_q <= 1'b1;
            resv_idx_q   <= idx_q;
          end else if (is_sc || (exec_we && (resv_idx_q == idx_q))) begin
            resv_valid_q <= 1'b0;
          end
          state_q <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_tag      = resp_tag_q;
  assign resp_has_data = resp_has_data_q;
  assign resp_error    = resp_error_q;

endmodule

// File: tb/tb_scratchpad_mem_responder.sv
// Self-checking bench for scratchpad_mem_responder: directed vector table,
// backpressure and reset corner sequences, then random ops against a dword-array model.
module tb_scratchpad_mem_responder;

  localparam int DEPTH  = 256;
  localparam int TAG_W  = 8;
  localparam int ADDR_W = 11;

  localparam logic [4:0] XRD = 5'd0,  XWR = 5'd1,  PFR = 5'd2,  PFW = 5'd3,  SWAP = 5'd4;
  localparam logic [4:0] FLA = 5'd5,  XLR = 5'd6,  XSC = 5'd7,  ADD = 5'd8,  XOR = 5'd9;
  localparam logic [4:0] AOR = 5'd10, AND = 5'd11, MIN = 5'd12, MAX = 5'd13, MINU = 5'd14;
  localparam logic [4:0] MAXU = 5'd15, FLU = 5'd16, PWR = 5'd17, PRO = 5'd18, CLN = 5'd19;
  localparam logic [4:0] SFN = 5'd20, WOK = 5'd23;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid, req_ready;
  logic [4:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [63:0]       req_data;
  logic [7:0]        req_mask;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid, resp_ready;
  logic [63:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_has_data, resp_error;

  always #5 clock = ~clock;

  scratchpad_mem_responder #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cmd       (req_cmd),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_data      (req_data),
    .req_mask      (req_mask),
    .req_tag       (req_tag),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_tag      (resp_tag),
    .resp_has_data (resp_has_data),
    .resp_error    (resp_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: plain dword array plus a single reservation.
  logic [63:0] m_mem [DEPTH];
  bit          m_rv = 1'b0;
  int          m_ri = 0;

  function automatic logic [31:0] amo32(input logic [4:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa = a;
    int sb = b;
    int unsigned ua = a;
    int unsigned ub = b;
    case (cmd)
      ADD:     return a + b;
      XOR:     return a ^ b;
      AOR:     return a | b;
      AND:     return a & b;
      MIN:     return (sa < sb) ? a : b;
      MAX:     return (sa > sb) ? a : b;
      MINU:    return (ua < ub) ? a : b;
      MAXU:    return (ua > ub) ? a : b;
      default: return b;
    endcase
  endfunction

  function automatic logic [63:0] amo64(input logic [4:0] cmd, input logic [63:0] a,
                                        input logic [63:0] b);
    longint sa = a;
    longint sb = b;
    longint unsigned ua = a;
    longint unsigned ub = b;
    case (cmd)
      ADD:     return a + b;
      XOR:     return a ^ b;
      AOR:     return a | b;
      AND:     return a & b;
      MIN:     return (sa < sb) ? a : b;
      MAX:     return (sa > sb) ? a : b;
      MINU:    return (ua < ub) ? a : b;
      MAXU:    return (ua > ub) ? a : b;
      default: return b;
    endcase
  endfunction

  function automatic logic [63:0] put_half(input logic [63:0] d, input logic hi,
                                           input logic [31:0] w);
    return hi ? {w, d[31:0]} : {d[63:32], w};
  endfunction

  task automatic model_op(input logic [4:0] cmd, input logic [ADDR_W-1:0] addr,
                          input logic [1:0] size, input logic [63:0] data,
                          input logic [7:0] mask, output logic [63:0] ed,
                          output logic eh, output logic ee);
    int          idx;
    logic [63:0] old, nw;
    logic [31:0] half;
    bit          wr;
    idx  = int'(addr[ADDR_W-1:3]);
    old  = m_mem[idx];
    nw   = old;
    half = addr[2] ? old[63:32] : old[31:0];
    wr   = 1'b0;
    ed = '0; eh = 1'b0; ee = 1'b0;
    case (cmd)
      XRD: begin ed = old; eh = 1'b1; end
      XWR, PWR: begin
        for (int b = 0; b < 8; b++) if (mask[b]) nw[8*b +: 8] = data[8*b +: 8];
        wr = 1'b1;
      end
      XLR: begin ed = old; eh = 1'b1; m_rv = 1'b1; m_ri = idx; end
      XSC: begin
        eh = 1'b1;
        if (m_rv && m_ri == idx) begin
          nw = (size == 2'd2) ? put_half(old, addr[2], data[31:0]) : data;
          wr = 1'b1;
        end else begin
          ed = 64'd1;
        end
        m_rv = 1'b0;
      end
      SWAP, ADD, XOR, AOR, AND, MIN, MAX, MINU, MAXU: begin
        ed = old; eh = 1'b1; wr = 1'b1;
        nw = (size == 2'd2) ? put_half(old, addr[2], amo32(cmd, half, data[31:0]))
                            : amo64(cmd, old, data);
      end
      PFR, PFW, FLA, FLU, PRO, CLN, SFN, WOK: ;
      default: ee = 1'b1;
    endcase
    if (wr) begin
      m_mem[idx] = nw;
      if (m_rv && m_ri == idx) m_rv = 1'b0;
    end
  endtask

  // Issue one request; returns at the falling edge where resp_valid is seen.
  task automatic do_req(input logic [4:0] cmd, input logic [ADDR_W-1:0] addr,
                        input logic [1:0] size, input logic [63:0] data,
                        input logic [7:0] mask, input logic [7:0] tag, output int lat);
    int w = 0;
    req_cmd = cmd; req_addr = addr; req_size = size; req_data = data;
    req_mask = mask; req_tag = tag; req_valid = 1'b1;
    @(negedge clock);
    while (!req_ready && w < 20) begin w++; @(negedge clock); end
    if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!resp_valid && lat < 20);
  endtask

  task automatic run_op(input string name, input logic [4:0] cmd,
                        input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                        input logic [63:0] data, input logic [7:0] mask,
                        input logic [7:0] tag, input logic [63:0] exp,
                        input logic eh, input logic ee);
    int lat;
    do_req(cmd, addr, size, data, mask, tag, lat);
    check({name, ".lat"}, 64'(lat), 64'd2);
    check({name, ".data"}, resp_data, exp);
    check({name, ".tag"}, 64'(resp_tag), 64'(tag));
    check({name, ".has"}, 64'(resp_has_data), 64'(eh));
    check({name, ".err"}, 64'(resp_error), 64'(ee));
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [4:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [63:0]       data;
    logic [7:0]        mask;
    logic [63:0]       exp;
    logic              eh;
    logic              ee;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] c, input logic [ADDR_W-1:0] a,
                              input logic [1:0] s, input logic [63:0] d, input logic [7:0] m,
                              input logic [63:0] e, input logic h, input logic r);
    vec_t v;
    v.cmd = c; v.addr = a; v.size = s; v.data = d; v.mask = m;
    v.exp = e; v.eh = h; v.ee = r;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [63:0] ed;
    logic        eh, ee;
    int          lat;

    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_cmd = '0; req_addr = '0; req_size = '0; req_data = '0; req_mask = '0; req_tag = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.req_ready", 64'(req_ready), 64'd0);
    check("rst.resp_valid", 64'(resp_valid), 64'd0);
    check("rst.resp_data", resp_data, 64'd0);
    check("rst.resp_tag", 64'(resp_tag), 64'd0);
    check("rst.flags", {62'd0, resp_has_data, resp_error}, 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rel.req_ready", 64'(req_ready), 64'd1);
    check("rel.resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clock);
    #1;

    vecs.push_back(mk(XWR,  11'h10, 2'd3, 64'h1122334455667788, 8'hff, 64'h0, 0, 0));
    vecs.push_back(mk(XRD,  11'h10, 2'd3, 64'h0, 8'h00, 64'h1122334455667788, 1, 0));
    vecs.push_back(mk(PWR,  11'h10, 2'd3, 64'hAA00, 8'h02, 64'h0, 0, 0));
    vecs.push_back(mk(XRD,  11'h10, 2'd3, 64'h0, 8'h00, 64'h112233445566AA88, 1, 0));
    vecs.push_back(mk(XWR,  11'h10, 2'd3, 64'hFFFFFFFF00000005, 8'hff, 64'h0, 0, 0));
    vecs.push_back(mk(ADD,  11'h14, 2'd2, 64'h1, 8'h00, 64'hFFFFFFFF00000005, 1, 0));
    vecs.push_back(mk(XRD,  11'h10, 2'd3, 64'h0, 8'h00, 64'h0000000000000005, 1, 0));
    vecs.push_back(mk(MIN,  11'h10, 2'd3, '1, 8'h00, 64'h5, 1, 0));
    vecs.push_back(mk(XRD,  11'h10, 2'd3, 64'h0, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1, 0));
    vecs.push_back(mk(XWR,  11'h20, 2'd3, 64'h0, 8'hff, 64'h0, 0, 0));
    vecs.push_back(mk(XLR,  11'h20, 2'd3, 64'h0, 8'h00, 64'h0, 1, 0));
    vecs.push_back(mk(XSC,  11'h20, 2'd3, 64'h7, 8'h00, 64'h0, 1, 0));
    vecs.push_back(mk(XRD,  11'h20, 2'd3, 64'h0, 8'h00, 64'h7, 1, 0));
    vecs.push_back(mk(XSC,  11'h20, 2'd3, 64'h9, 8'h00, 64'h1, 1, 0));
    vecs.push_back(mk(XRD,  11'h20, 2'd3, 64'h0, 8'h00, 64'h7, 1, 0));
    vecs.push_back(mk(XLR,  11'h20, 2'd3, 64'h0, 8'h00, 64'h7, 1, 0));
    vecs.push_back(mk(XWR,  11'h20, 2'd3, 64'h55, 8'hff, 64'h0, 0, 0));
    vecs.push_back(mk(XSC,  11'h20, 2'd3, 64'h99, 8'h00, 64'h1, 1, 0));
    vecs.push_back(mk(XRD,  11'h20, 2'd3, 64'h0, 8'h00, 64'h55, 1, 0));
    vecs.push_back(mk(5'h15, 11'h20, 2'd3, 64'h1234, 8'hff, 64'h0, 0, 1));
    vecs.push_back(mk(PFW,  11'h20, 2'd3, 64'hFFFF, 8'hff, 64'h0, 0, 0));
    vecs.push_back(mk(XWR,  11'h20, 2'd3, '1, 8'h00, 64'h0, 0, 0));
    vecs.push_back(mk(XRD,  11'h20, 2'd3, 64'h0, 8'h00, 64'h55, 1, 0));
    vecs.push_back(mk(XLR,  11'h20, 2'd3, 64'h0, 8'h00, 64'h55, 1, 0));
    vecs.push_back(mk(XSC,  11'h24, 2'd2, 64'hABCD, 8'h00, 64'h0, 1, 0));
    vecs.push_back(mk(XRD,  11'h20, 2'd3, 64'h0, 8'h00, 64'h0000ABCD00000055, 1, 0));
    vecs.push_back(mk(MAX,  11'h20, 2'd2, 64'h80000000, 8'h00, 64'h0000ABCD00000055, 1, 0));
    vecs.push_back(mk(MAXU, 11'h20, 2'd2, 64'h80000000, 8'h00, 64'h0000ABCD00000055, 1, 0));
    vecs.push_back(mk(XRD,  11'h20, 2'd3, 64'h0, 8'h00, 64'h0000ABCD80000000, 1, 0));
    vecs.push_back(mk(SWAP, 11'h20, 2'd3, 64'h0123456789ABCDEF, 8'h00,
                      64'h0000ABCD80000000, 1, 0));
    vecs.push_back(mk(XOR,  11'h24, 2'd2, 64'hFFFFFFFF, 8'h00, 64'h0123456789ABCDEF, 1, 0));
    vecs.push_back(mk(XRD,  11'h20, 2'd3, 64'h0, 8'h00, 64'hFEDCBA9889ABCDEF, 1, 0));
    vecs.push_back(mk(FLA,  11'h20, 2'd3, 64'h0, 8'h00, 64'h0, 0, 0));

    foreach (vecs[i]) begin
      model_op(vecs[i].cmd, vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].mask, ed, eh, ee);
      run_op($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].size, vecs[i].data,
             vecs[i].mask, 8'(i + 1), vecs[i].exp, vecs[i].eh, vecs[i].ee);
    end

    // Backpressure: hold a tagged response for 5 cycles.
    resp_ready = 1'b0;
    model_op(XRD, 11'h20, 2'd3, 64'h0, 8'h00, ed, eh, ee);
    do_req(XRD, 11'h20, 2'd3, 64'h0, 8'h00, 8'h3C, lat);
    check("bp.lat", 64'(lat), 64'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("bp.valid", 64'(resp_valid), 64'd1);
      check("bp.tag", 64'(resp_tag), 64'h3C);
      check("bp.data", resp_data, 64'hFEDCBA9889ABCDEF);
      check("bp.req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    model_op(XRD, 11'h10, 2'd3, 64'h0, 8'h00, ed, eh, ee);
    run_op("bp.resume", XRD, 11'h10, 2'd3, 64'h0, 8'h00, 8'h3D, ed, eh, ee);

    // Reset while holding an LR response drops it and clears the reservation.
    model_op(XWR, 11'h30, 2'd3, 64'hC0FFEE, 8'hff, ed, eh, ee);
    run_op("mr.init", XWR, 11'h30, 2'd3, 64'hC0FFEE, 8'hff, 8'h40, ed, eh, ee);
    resp_ready = 1'b0;
    model_op(XLR, 11'h30, 2'd3, 64'h0, 8'h00, ed, eh, ee);
    do_req(XLR, 11'h30, 2'd3, 64'h0, 8'h00, 8'h41, lat);
    check("mr.lr_data", resp_data, 64'hC0FFEE);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mr.resp_valid", 64'(resp_valid), 64'd0);
    check("mr.req_ready", 64'(req_ready), 64'd0);
    m_rv = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1; resp_ready = 1'b1;
    model_op(XSC, 11'h30, 2'd3, 64'h1, 8'h00, ed, eh, ee);
    run_op("mr.sc_fail", XSC, 11'h30, 2'd3, 64'h1, 8'h00, 8'h42, 64'h1, 1'b1, 1'b0);
    model_op(XRD, 11'h30, 2'd3, 64'h0, 8'h00, ed, eh, ee);
    run_op("mr.rd", XRD, 11'h30, 2'd3, 64'h0, 8'h00, 8'h43, 64'hC0FFEE, 1'b1, 1'b0);

    // Random phase over a few dwords so LR/SC pairs and AMOs collide often.
    for (int i = 0; i < 4; i++) begin
      logic [63:0] d = {$urandom, $urandom};
      model_op(XWR, ADDR_W'(i * 8), 2'd3, d, 8'hff, ed, eh, ee);
      run_op("rinit", XWR, ADDR_W'(i * 8), 2'd3, d, 8'hff, 8'(i), ed, eh, ee);
    end
    for (int n = 0; n < 300; n++) begin
      logic [4:0]        c;
      logic [ADDR_W-1:0] a;
      logic [1:0]        s;
      logic [63:0]       d;
      logic [7:0]        m, t;
      if ($urandom_range(0, 4) == 0) begin
        c = 5'($urandom_range(0, 31));
      end else begin
        case ($urandom_range(0, 6))
          0:       c = XRD;
          1:       c = ($urandom_range(0, 1) != 0) ? XWR : PWR;
          2, 3:    c = XLR;
          4, 5:    c = XSC;
          default: c = ($urandom_range(0, 8) == 0) ? SWAP : 5'($urandom_range(8, 15));
        endcase
      end
      a = ADDR_W'($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
      s = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd3;
      d = {$urandom, $urandom};
      m = 8'($urandom_range(1, 255));
      t = 8'($urandom);
      model_op(c, a, s, d, m, ed, eh, ee);
      run_op($sformatf("rnd%0d.cmd%0d", n, c), c, a, s, d, m, t, ed, eh, ee);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scratchpad_mem_responder.md
# scratchpad_mem_responder

Memory-side responder for the cache command set (`M_*` encodings, 5-bit `cmd`). It accepts one request at a time, executes it against a local single-port 64-bit scratchpad, and returns a tagged response. Supported operations are loads, stores, partial stores, LR/SC and all AMOs; prefetch and flush-class commands complete with a plain acknowledge. It sits behind the data-cache request arbiter as the backing store for uncached/scratchpad regions.

## Interface

**Parameters**
- `DEPTH`, default 256: number of 64-bit dwords; power of two.
- `TAG_W`, default 8: width of the request tag.
- `ADDR_W`, default `$clog2(DEPTH)+3`: byte address width.

**Ports**
- `clock`, in, 1: single clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, 1: request valid.
- `req_ready`, out, 1: request ready.
- `req_cmd`, in, 5: `M_*` command.
- `req_addr`, in, `ADDR_W`: byte address. Bits [2:0] are ignored except `addr[2]` when size is 2.
- `req_size`, in, 2: 2 = 32-bit, 3 = 64-bit. Used only by AMO and SC.
- `req_data`, in, 64: store, AMO or SC operand.
- `req_mask`, in, 8: byte enables for `M_XWR`/`M_PWR`.
- `req_tag`, in, `TAG_W`: returned unchanged with the response.
- `resp_valid`, out, 1: response valid.
- `resp_ready`, in, 1: response ready.
- `resp_data`, out, 64: old dword, or SC status.
- `resp_tag`, out, `TAG_W`: tag of the request being answered.
- `resp_has_data`, out, 1: 1 for `XRD`/`XLR`/`XSC`/AMO.
- `resp_error`, out, 1: unsupported command.

## Operation

**State machine**
- States: IDLE, EXEC, RESP.
- `req_ready` = 1 only in IDLE.
- IDLE → EXEC on `req_valid`. At that point the request is registered and the SRAM read of index `addr[ADDR_W-1:3]` is issued.
- EXEC: SRAM read data is valid. Compute the result, perform the write if one is required, load the response registers, then go to RESP.
- RESP: hold the response until `resp_ready`, then go to IDLE.

**Command behaviour**
- `M_XRD`: `resp_data` = dword. No write.
- `M_XWR`, `M_PWR`: byte-masked write of `req_data`. `resp_data` = 0. A mask of 0 writes nothing.
- `M_XLR`: read the dword; set the reservation to {valid=1, index}.
- `M_XSC`:
  - Success when the reservation is valid and its index matches the request index. On success, write (64-bit, or the 32-bit half selected by `addr[2]`) and `resp_data` = 0.
  - Otherwise no write and `resp_data` = 1.
  - The reservation is cleared in both cases.
- AMO (`SWAP`/`ADD`/`XOR`/`OR`/`AND`/`MIN`/`MAX`/`MINU`/`MAXU`):
  - new = op(old, `req_data`). Write new; `resp_data` = full old dword.
  - Size 2: operate on the 32-bit half selected by `addr[2]`, using the low 32 bits of `req_data`. MIN/MAX compare signed 32-bit, MINU/MAXU compare unsigned 32-bit, ADD wraps mod 2^32. The other half is unchanged.
  - Size 3: 64-bit arithmetic, wrapping.
- `M_PFR`, `M_PFW`, `M_FLUSH_ALL`, `M_FLUSH`, `M_PRODUCE`, `M_CLEAN`, `M_SFENCE`, `M_WOK`: no access, `resp_data` = 0, `resp_has_data` = 0.
- Any other encoding: no access, `resp_error` = 1.

**Reservation**
- Cleared on reset and by any SC.
- Cleared by any committed write (store, AMO, successful SC) to the reserved index.

## Timing

- Reset values: `req_ready` = 0 while `reset_n` = 0 and 1 in the first cycle after release; `resp_valid` = 0; `resp_data`, `resp_tag`, `resp_has_data`, `resp_error` = 0; state = IDLE; reservation invalid. SRAM contents are not reset.
- Latency: `resp_valid` rises 2 cycles after the accepting edge (cycle 0 accept, cycle 1 EXEC, cycle 2 RESP). With `resp_ready` held high, throughput is one request per 3 cycles.
- Response outputs are registered and stable while `resp_valid` && !`resp_ready`.
- The SRAM write commits at the EXEC clock edge. A request accepted after a response sees that write.
- Reset asserted mid-operation returns the block to IDLE next edge: any pending response is dropped and the reservation is cleared. A write commits only if EXEC's edge precedes the reset edge.

## Structure

- Shared package (extend the memory-op constants package):
  - `M_*` localparams.
  - Functions `isAMO`, `isWrite`, `isPrefetch`, plus a new `isFlushClass(cmd)`.
  - typedef `amo_op_e`.
- Sub-module `amo_alu`: combinational (`cmd`, `size`, `addr2`, `old`, `operand`) → new dword plus 8-bit write mask.
- SRAM: a behavioural array inside the responder, one read or write per cycle.

## Test plan

- Reset release → `req_ready` = 1, `resp_valid` = 0. Then `XWR` addr 0x10, data 0x1122334455667788, mask 0xFF; then `XRD` 0x10 → `resp_data` 0x1122334455667788, `resp_has_data` = 1, `resp_valid` 2 cycles after accept.
- `PWR` 0x10, data 0xAA00, mask 0x02 → `XRD` returns 0x112233445566AA88.
- `AMO_ADD` size 2, addr 0x14, data 1, on dword 0xFFFFFFFF_00000005 → resp 0xFFFFFFFF_00000005; memory becomes 0x00000000_00000005 (32-bit wrap, low half untouched). `AMO_MIN` size 3, data -1, on 5 → memory 0xFFFF_FFFF_FFFF_FFFF.
- `XLR` 0x20, then `XSC` 0x20 data 7 → resp 0, memory 7. Repeat SC → resp 1. `XLR` 0x20, `XWR` 0x20, `XSC` 0x20 → resp 1, no write.
- `resp_ready` = 0 for 5 cycles on a tag 0x3C response → outputs held and `req_ready` = 0 throughout; release → accept resumes. `cmd` 0x15 → `resp_error` = 1. `M_PFW` → `resp_data` 0, no memory change.
- Assert `reset_n` = 0 while in RESP → next cycle `resp_valid` = 0; a subsequent `XSC` fails (reservation cleared).
